// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned DEF_AW = 3;
    localparam int unsigned DEF_DW = 16;
    localparam int unsigned CNT_W  = 4;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way requester picker; round-robin on ties when RAM_ARB_RR_EN is defined,
// fixed priority (A first) otherwise.
module rr_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner_c,
    output logic       valid_c
);

    assign valid_c = |req;

`ifdef RAM_ARB_RR_EN
    always_comb begin
        winner_c = REQ_A;
        if (req == 2'b11) begin
            winner_c = (last == REQ_A) ? REQ_B : REQ_A;
        end else if (req[1]) begin
            winner_c = REQ_B;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        winner_c = REQ_A;
        if (!req[0] && req[1]) begin
            winner_c = REQ_B;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one 16-bit RAM macro between requesters A and B with a fixed
// SETUP/ACCESS/DONE strobe sequence. Define RAM_ARB_RR_EN for round-robin ties.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          a_ack,
    output logic          b_gnt,
    output logic          b_ack,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    output logic          mem_RW,
    output logic          mem_CS,
    output logic          mem_OE,
    input  logic [DW-1:0] mem_out
);

    state_t           state;
    state_t           state_next;
    logic             we_l;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             pick_winner;
    logic             pick_valid;

    logic cs_d, rw_d, oe_d;
    logic a_gnt_d, b_gnt_d, a_ack_d, b_ack_d;

`ifdef RAM_ARB_RR_EN
    logic last_winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= REQ_B;
        end else if (state == DONE) begin
            last_winner <= owner;
        end
    end

    assign last = last_winner;
`else
    assign last = REQ_B;
`endif

    rr_pick u_pick (
        .req      ({b_req, a_req}),
        .last     (last),
        .winner_c (pick_winner),
        .valid_c  (pick_valid)
    );

    // State register plus the latched request, wait counter and read capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            we_l     <= 1'b0;
            owner    <= REQ_A;
            cnt      <= '0;
            mem_addr <= '0;
            mem_in   <= '0;
            rdata    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner    <= pick_winner;
                        we_l     <= (pick_winner == REQ_B) ? b_we    : a_we;
                        mem_addr <= (pick_winner == REQ_B) ? b_addr  : a_addr;
                        mem_in   <= (pick_winner == REQ_B) ? b_wdata : a_wdata;
                    end
                end
                SETUP: cnt <= CNT_W'(WAIT_CYC - 1);
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (!we_l) begin
                        rdata <= mem_out;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they can be registered
    always_comb begin
        cs_d    = 1'b0;
        rw_d    = 1'b0;
        oe_d    = 1'b0;
        a_gnt_d = 1'b0;
        b_gnt_d = 1'b0;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        case (state_next)
            SETUP:  cs_d = 1'b1;
            ACCESS: begin
                cs_d = 1'b1;
                rw_d = we_l;
                oe_d = ~we_l;
            end
            DONE: begin
                a_ack_d = (owner == REQ_A);
                b_ack_d = (owner == REQ_B);
            end
            default: ;
        endcase
        if (state == IDLE) begin
            a_gnt_d = pick_valid && (pick_winner == REQ_A);
            b_gnt_d = pick_valid && (pick_winner == REQ_B);
        end else if (state_next != IDLE) begin
            a_gnt_d = (owner == REQ_A);
            b_gnt_d = (owner == REQ_B);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_CS <= 1'b0;
            mem_RW <= 1'b0;
            mem_OE <= 1'b0;
            a_gnt  <= 1'b0;
            b_gnt  <= 1'b0;
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
        end else begin
            mem_CS <= cs_d;
            mem_RW <= rw_d;
            mem_OE <= oe_d;
            a_gnt  <= a_gnt_d;
            b_gnt  <= b_gnt_d;
            a_ack  <= a_ack_d;
            b_ack  <= b_ack_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with WAIT_CYC=1, one with WAIT_CYC=3,
// each backed by a small behavioural RAM.
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WAIT_CYC = 1 instance
    logic        a_req, a_we, b_req, b_we;
    logic [2:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_ack, b_gnt, b_ack;
    logic [15:0] rdata, mem_in;
    logic [2:0]  mem_addr;
    logic        mem_rw, mem_cs, mem_oe;
    wire  [15:0] mem_out;
    logic [15:0] ram1 [8];

    ram_arbiter #(.AW(3), .DW(16), .WAIT_CYC(1)) u_dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .b_gnt(b_gnt), .b_ack(b_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_RW(mem_rw), .mem_CS(mem_cs), .mem_OE(mem_oe), .mem_out(mem_out)
    );

    always @(posedge clk) if (mem_cs && mem_rw) ram1[mem_addr] <= mem_in;
    assign mem_out = (mem_cs && mem_oe) ? ram1[mem_addr] : 16'hzzzz;

    // WAIT_CYC = 3 instance
    logic        a3_req, a3_we, b3_req, b3_we;
    logic [2:0]  a3_addr, b3_addr;
    logic [15:0] a3_wdata, b3_wdata;
    logic        a3_gnt, a3_ack, b3_gnt, b3_ack;
    logic [15:0] rdata3, mem_in3;
    logic [2:0]  mem_addr3;
    logic        mem_rw3, mem_cs3, mem_oe3;
    wire  [15:0] mem_out3;
    logic [15:0] ram3 [8];

    ram_arbiter #(.AW(3), .DW(16), .WAIT_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
        .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
        .a_gnt(a3_gnt), .a_ack(a3_ack), .b_gnt(b3_gnt), .b_ack(b3_ack),
        .rdata(rdata3), .mem_addr(mem_addr3), .mem_in(mem_in3),
        .mem_RW(mem_rw3), .mem_CS(mem_cs3), .mem_OE(mem_oe3), .mem_out(mem_out3)
    );

    always @(posedge clk) if (mem_cs3 && mem_rw3) ram3[mem_addr3] <= mem_in3;
    assign mem_out3 = (mem_cs3 && mem_oe3) ? ram3[mem_addr3] : 16'hzzzz;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef RAM_ARB_RR_EN
    localparam logic [3:0] TIE_PAT = 4'b1010;  // bit k set: B wins tie k
`else
    localparam logic [3:0] TIE_PAT = 4'b0000;
`endif

    initial begin
        logic [3:0]  tie_pat;
        logic        exp_b;
        logic        saw_b_ack;
        logic        got;
        tie_pat = TIE_PAT;

        rst = 1'b1;
        {a_req, a_we, b_req, b_we} = '0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        {a3_req, a3_we, b3_req, b3_we} = '0;
        a3_addr = '0; b3_addr = '0; a3_wdata = '0; b3_wdata = '0;
        tick();
        tick();

        // Reset values
        chk("rst_strobes", {29'd0, mem_cs, mem_rw, mem_oe}, 32'd0);
        chk("rst_addr",    {29'd0, mem_addr}, 32'd0);
        chk("rst_in",      {16'd0, mem_in}, 32'd0);
        chk("rst_rdata",   {16'd0, rdata}, 32'd0);
        chk("rst_gnt_ack", {28'd0, a_gnt, b_gnt, a_ack, b_ack}, 32'd0);
        chk("rst3_outs",   {27'd0, a3_gnt, b3_gnt, a3_ack, b3_ack, mem_cs3}, 32'd0);
        rst = 1'b0;
        tick();

        // A writes BEEF to addr 5
        a_we = 1'b1; a_addr = 3'd5; a_wdata = 16'hBEEF; a_req = 1'b1;
        tick();
        chk("wr_setup_gnt", {31'd0, a_gnt}, 32'd1);
        chk("wr_setup_str", {29'd0, mem_cs, mem_rw, mem_oe}, 32'b100);
        chk("wr_setup_addr", {29'd0, mem_addr}, 32'd5);
        chk("wr_setup_in", {16'd0, mem_in}, 32'hBEEF);
        a_addr = 3'd7; a_wdata = 16'h0000;
        tick();
        chk("wr_access_str", {29'd0, mem_cs, mem_rw, mem_oe}, 32'b110);
        chk("wr_latched_addr", {29'd0, mem_addr}, 32'd5);
        chk("wr_latched_in", {16'd0, mem_in}, 32'hBEEF);
        chk("wr_access_noack", {31'd0, a_ack}, 32'd0);
        tick();
        chk("wr_done_ack", {31'd0, a_ack}, 32'd1);
        chk("wr_done_str", {29'd0, mem_cs, mem_rw, mem_oe}, 32'b000);
        a_req = 1'b0;
        tick();
        chk("wr_idle", {29'd0, a_gnt, a_ack, mem_cs}, 32'd0);

        // A reads addr 5
        a_we = 1'b0; a_addr = 3'd5; a_req = 1'b1;
        tick();
        chk("rd_setup_str", {29'd0, mem_cs, mem_rw, mem_oe}, 32'b100);
        tick();
        chk("rd_access_str", {29'd0, mem_cs, mem_rw, mem_oe}, 32'b101);
        tick();
        chk("rd_done_ack", {31'd0, a_ack}, 32'd1);
        chk("rd_done_rdata", {16'd0, rdata}, 32'hBEEF);
        chk("rd_done_oe", {31'd0, mem_oe}, 32'd0);
        a_req = 1'b0;
        tick();

        // B alone writes 5A5A to addr 3; rdata untouched
        b_we = 1'b1; b_addr = 3'd3; b_wdata = 16'h5A5A; b_req = 1'b1;
        tick();
        chk("bw_gnt", {30'd0, a_gnt, b_gnt}, 32'b01);
        chk("bw_addr", {29'd0, mem_addr}, 32'd3);
        tick();
        tick();
        chk("bw_ack", {30'd0, a_ack, b_ack}, 32'b01);
        chk("bw_rdata_kept", {16'd0, rdata}, 32'hBEEF);
        b_req = 1'b0;
        tick();

        // Tie with both requests held across four transfers
        a_we = 1'b0; a_addr = 3'd5; b_we = 1'b0; b_addr = 3'd3;
        a_req = 1'b1; b_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_b = tie_pat[k];
            tick();
            chk($sformatf("tie%0d_gnt", k), {30'd0, a_gnt, b_gnt}, {30'd0, ~exp_b, exp_b});
            tick();
            tick();
            chk($sformatf("tie%0d_ack", k), {30'd0, a_ack, b_ack}, {30'd0, ~exp_b, exp_b});
            chk($sformatf("tie%0d_rdata", k), {16'd0, rdata}, exp_b ? 32'h5A5A : 32'hBEEF);
            if (k == 3) begin
                a_req = 1'b0; b_req = 1'b0;
            end
            tick();
        end

        // Reset pulsed during ACCESS of a B write
        b_we = 1'b1; b_addr = 3'd6; b_wdata = 16'hAAAA; b_req = 1'b1;
        tick();
        tick();
        chk("rst_mid_access", {29'd0, mem_cs, mem_rw, mem_oe}, 32'b110);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", {29'd0, mem_cs, mem_rw, mem_oe}, 32'd0);
        chk("rst_mid_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
        chk("rst_mid_rdata", {16'd0, rdata}, 32'd0);
        b_req = 1'b0;
        tick();
        rst = 1'b0;
        saw_b_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw_b_ack = saw_b_ack | b_ack;
        end
        chk("rst_no_b_ack", {31'd0, saw_b_ack}, 32'd0);
        chk("rst_idle", {29'd0, mem_cs, a_gnt, b_gnt}, 32'd0);
        a_we = 1'b0; b_we = 1'b0; a_req = 1'b1; b_req = 1'b1;
        tick();
        chk("post_rst_tie", {30'd0, a_gnt, b_gnt}, 32'b10);
        tick();
        tick();
        chk("post_rst_ack", {30'd0, a_ack, b_ack}, 32'b10);
        a_req = 1'b0; b_req = 1'b0;
        tick();

        // WAIT_CYC=3: write 1234 to addr 2, then read it back
        a3_we = 1'b1; a3_addr = 3'd2; a3_wdata = 16'h1234; a3_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            got = a3_ack;
        end
        chk("w3_ack", {31'd0, got}, 32'd1);
        a3_req = 1'b0;
        tick();
        a3_we = 1'b0; a3_addr = 3'd2; a3_req = 1'b1;
        tick();
        chk("r3_setup_str", {29'd0, mem_cs3, mem_rw3, mem_oe3}, 32'b100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("r3_access%0d", i), {28'd0, mem_cs3, mem_rw3, mem_oe3, a3_ack}, 32'b1010);
        end
        tick();
        chk("r3_ack", {31'd0, a3_ack}, 32'd1);
        chk("r3_rdata", {16'd0, rdata3}, 32'h1234);
        chk("r3_done_oe", {31'd0, mem_oe3}, 32'd0);
        a3_req = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
